// File: rtl/serial_display_sequencer.sv
// serial_display_sequencer
//
// Builds a 32-bit seven-segment frame (HH:MM, hours-tens blanked when zero,
// colon on the hours-ones decimal point) and shifts it MSB first into an
// external shift register, then strobes the storage latch.
//
// Parameters
//   CLK_DIV         i_clk cycles per half-period of o_serial_clk (>= 1)
//
// Ports
//   i_clk           system clock, rising edge only
//   i_reset_n       asynchronous active-low reset
//   i_en            block enable; low returns the sequencer to IDLE
//   i_start         frame request, honoured in IDLE only
//   i_hours_bcd     hours   {tens, ones} BCD
//   i_minutes_bcd   minutes {tens, ones} BCD
//   i_colon         colon indicator (hours-ones decimal point)
//   o_busy          frame in progress (LOAD/SHIFT/LATCH)
//   o_done          one-cycle pulse when a frame completes
//   o_serial_data   shift register data line
//   o_serial_clk    shift clock, data sampled externally on its rising edge
//   o_serial_latch  storage latch strobe, active high
module serial_display_sequencer #(
   parameter int CLK_DIV = 2
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_en,
   input  logic       i_start,
   input  logic [7:0] i_hours_bcd,
   input  logic [7:0] i_minutes_bcd,
   input  logic       i_colon,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_serial_data,
   output logic       o_serial_clk,
   output logic       o_serial_latch
);

   // Divider counts CLK_DIV-1 down to 0 within each timed state.
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ZERO   = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      LATCH    = 3'd4,
      DONE     = 3'd5
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [DIV_W-1:0]  div_r;
   logic [DIV_W-1:0]  div_s;
   logic [4:0]        bit_r;
   logic [4:0]        bit_s;
   logic [31:0]       frame_r;
   logic [31:0]       frame_s;

   logic              busy_r, busy_s;
   logic              done_r, done_s;
   logic              data_r, data_s;
   logic              sclk_r, sclk_s;
   logic              latch_r, latch_s;

   // Seven-segment encoding {dp,g,f,e,d,c,b,a}; non-decimal codes show a dash.
   function automatic logic [7:0] seg_encode(
      input logic [3:0] digit,
      input logic       dp,
      input logic       blank_zero
   );
      logic [6:0] segs;
      case (digit)
         4'd0:    segs = 7'h3F;
         4'd1:    segs = 7'h06;
         4'd2:    segs = 7'h5B;
         4'd3:    segs = 7'h4F;
         4'd4:    segs = 7'h66;
         4'd5:    segs = 7'h6D;
         4'd6:    segs = 7'h7D;
         4'd7:    segs = 7'h07;
         4'd8:    segs = 7'h7F;
         4'd9:    segs = 7'h6F;
         default: segs = 7'h40;
      endcase
      if (blank_zero && (digit == 4'd0)) begin
         return 8'h00;
      end else begin
         return {dp, segs};
      end
   endfunction

   // Next-state, counter and next-output logic; outputs are registered from
   // the next state so they line up exactly with the state they describe.
   always_comb begin
      state_s = state_r;
      bit_s   = bit_r;
      frame_s = frame_r;
      div_s   = div_r;

      if (!i_en) begin
         state_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (i_start) begin
                  state_s = LOAD;
                  frame_s = {seg_encode(i_hours_bcd[7:4],   1'b0,    1'b1),
                             seg_encode(i_hours_bcd[3:0],   i_colon, 1'b0),
                             seg_encode(i_minutes_bcd[7:4], 1'b0,    1'b0),
                             seg_encode(i_minutes_bcd[3:0], 1'b0,    1'b0)};
               end else begin
                  state_s = IDLE;
               end
            end
            LOAD: begin
               state_s = SHIFT_LO;
               bit_s   = 5'd31;
            end
            SHIFT_LO: begin
               if (div_r == DIV_ZERO) begin
                  state_s = SHIFT_HI;
               end else begin
                  state_s = SHIFT_LO;
               end
            end
            SHIFT_HI: begin
               if (div_r != DIV_ZERO) begin
                  state_s = SHIFT_HI;
               end else if (bit_r == 5'd0) begin
                  state_s = LATCH;
               end else begin
                  // Next bit appears on entry to SHIFT_LO.
                  state_s = SHIFT_LO;
                  bit_s   = bit_r - 5'd1;
                  frame_s = {frame_r[30:0], 1'b0};
               end
            end
            LATCH: begin
               if (div_r == DIV_ZERO) begin
                  state_s = DONE;
               end else begin
                  state_s = LATCH;
               end
            end
            DONE: begin
               state_s = IDLE;
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end

      // Divider reloads on every state change, otherwise counts down.
      if (state_s != state_r) begin
         div_s = DIV_RELOAD;
      end else if (div_r != DIV_ZERO) begin
         div_s = div_r - DIV_ONE;
      end else begin
         div_s = div_r;
      end

      busy_s  = (state_s == LOAD) || (state_s == SHIFT_LO) ||
                (state_s == SHIFT_HI) || (state_s == LATCH);
      done_s  = (state_s == DONE);
      sclk_s  = (state_s == SHIFT_HI);
      latch_s = (state_s == LATCH);
      if ((state_s == LOAD) || (state_s == SHIFT_LO) || (state_s == SHIFT_HI)) begin
         data_s = frame_s[31];
      end else begin
         data_s = 1'b0;
      end
   end

   // State, counters, frame and registered outputs.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r <= IDLE;
         div_r   <= DIV_ZERO;
         bit_r   <= 5'd0;
         frame_r <= 32'h0000_0000;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         data_r  <= 1'b0;
         sclk_r  <= 1'b0;
         latch_r <= 1'b0;
      end else begin
         state_r <= state_s;
         div_r   <= div_s;
         bit_r   <= bit_s;
         frame_r <= frame_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         data_r  <= data_s;
         sclk_r  <= sclk_s;
         latch_r <= latch_s;
      end
   end

   assign o_busy         = busy_r;
   assign o_done         = done_r;
   assign o_serial_data  = data_r;
   assign o_serial_clk   = sclk_r;
   assign o_serial_latch = latch_r;

endmodule

// File: tb/tb_serial_display_sequencer.sv
// Testbench for serial_display_sequencer: three instances (CLK_DIV = 2, 1, 3)
// share all inputs. Expected frames are queued per instance when a start is
// issued; a monitor reassembles each shifted word from the serial lines and
// checks it, plus its timing, when o_done arrives.
module tb_serial_display_sequencer;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       start;
   logic [7:0] hours;
   logic [7:0] minutes;
   logic       colon;
   logic [2:0] busy, done, sdata, sclk, latch;

   int cyc = 0;
   int total = 0;
   int bad = 0;

   typedef struct {
      logic [31:0] word;
      int          start;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   logic [7:0] seg_tab [0:15] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                  8'h7F, 8'h6F, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int D = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
      serial_display_sequencer #(.CLK_DIV(D)) u_dut (
         .i_clk          (clk),
         .i_reset_n      (rst_n),
         .i_en           (en),
         .i_start        (start),
         .i_hours_bcd    (hours),
         .i_minutes_bcd  (minutes),
         .i_colon        (colon),
         .o_busy         (busy[g]),
         .o_done         (done[g]),
         .o_serial_data  (sdata[g]),
         .o_serial_clk   (sclk[g]),
         .o_serial_latch (latch[g])
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int div_of(input int i);
      case (i)
         0:       return 2;
         1:       return 1;
         default: return 3;
      endcase
   endfunction

   function automatic logic [31:0] model_word(input logic [7:0] h, input logic [7:0] m,
                                              input logic c);
      logic [7:0] b3, b2, b1, b0;
      b3 = (h[7:4] == 4'd0) ? 8'h00 : seg_tab[h[7:4]];
      b2 = seg_tab[h[3:0]] | (c ? 8'h80 : 8'h00);
      b1 = seg_tab[m[7:4]];
      b0 = seg_tab[m[3:0]];
      return {b3, b2, b1, b0};
   endfunction

   function automatic logic [4:0] outs_of(input int i);
      return {busy[i], done[i], sdata[i], sclk[i], latch[i]};
   endfunction

   task automatic check(input string name, input int inst, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst=%0d got=%0h expected=%0h (t=%0t cyc=%0d)",
                  name, inst, act, exp, $time, cyc);
      end
   endtask

   task automatic push_one(input int i, input logic [31:0] w, input int n);
      exp_t e;
      e.word  = w;
      e.start = n;
      case (i)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic push_all(input logic [31:0] w, input int n);
      for (int i = 0; i < 3; i++) push_one(i, w, n);
   endtask

   // Callers are always positioned 1 time unit after a rising edge.
   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_frame(input logic [7:0] h, input logic [7:0] m, input logic c,
                              output int n);
      hours   = h;
      minutes = m;
      colon   = c;
      start   = 1'b1;
      n       = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic check_all_zero(input string name);
      for (int i = 0; i < 3; i++) check(name, i, 32'(outs_of(i)), 32'd0);
   endtask

   // Monitor: reassemble the serial word and check every completed frame.
   initial begin : monitor
      logic        prev_busy [3];
      logic        prev_sclk [3];
      logic [31:0] shreg [3];
      int          nbits [3];
      int          last_rise [3];
      int          per_err [3];
      int          lat_first [3];
      int          lat_len [3];
      int          lat_err [3];
      exp_t        e;
      int          qs;
      for (int i = 0; i < 3; i++) begin
         prev_busy[i] = 1'b0;
         prev_sclk[i] = 1'b0;
         shreg[i]     = 32'd0;
         nbits[i]     = 0;
         last_rise[i] = -1;
         per_err[i]   = 0;
         lat_first[i] = -1;
         lat_len[i]   = 0;
         lat_err[i]   = 0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (busy[i] && !prev_busy[i]) begin
               nbits[i]     = 0;
               last_rise[i] = -1;
               per_err[i]   = 0;
               lat_first[i] = -1;
               lat_len[i]   = 0;
               lat_err[i]   = 0;
            end
            if (sclk[i] && !prev_sclk[i]) begin
               shreg[i] = {shreg[i][30:0], sdata[i]};
               nbits[i]++;
               if (last_rise[i] >= 0 && (cyc - last_rise[i]) != 2 * div_of(i)) per_err[i]++;
               last_rise[i] = cyc;
            end
            if (sclk[i] && (sdata[i] != shreg[i][0])) per_err[i]++;
            if (latch[i]) begin
               if (lat_len[i] == 0) lat_first[i] = cyc;
               lat_len[i]++;
               if (sdata[i] || sclk[i] || !busy[i]) lat_err[i]++;
            end
            if (done[i]) begin
               case (i)
                  0:       qs = q0.size();
                  1:       qs = q1.size();
                  default: qs = q2.size();
               endcase
               check("done_has_expected_frame", i, 32'(qs != 0), 32'd1);
               if (qs != 0) begin
                  case (i)
                     0:       e = q0.pop_front();
                     1:       e = q1.pop_front();
                     default: e = q2.pop_front();
                  endcase
                  check("shifted_word", i, shreg[i], e.word);
                  check("bit_count", i, nbits[i], 32'd32);
                  check("done_cycle", i, cyc, e.start + 2 + 65 * div_of(i));
                  check("latch_first_cycle", i, lat_first[i], e.start + 2 + 64 * div_of(i));
                  check("latch_length", i, lat_len[i], div_of(i));
                  check("sclk_period_and_stability", i, per_err[i], 32'd0);
                  check("latch_lines_quiet", i, lat_err[i], 32'd0);
                  check("busy_low_in_done", i, 32'(busy[i]), 32'd0);
               end
            end
            prev_busy[i] = busy[i];
            prev_sclk[i] = sclk[i];
         end
      end
   end

   // Stimulus.
   initial begin : stimulus
      int n;
      int s;
      int found;
      logic [7:0] h, m;
      logic c;
      rst_n   = 1'b0;
      en      = 1'b0;
      start   = 1'b0;
      hours   = 8'h00;
      minutes = 8'h00;
      colon   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset_outputs");
      rst_n = 1'b1;
      en    = 1'b1;
      @(posedge clk);
      #1;

      // Directed words.
      start_frame(8'h12, 8'h34, 1'b1, n);
      push_all(32'h06DB4F66, n);
      goto(n + 2 + 65 * 3 + 3);
      start_frame(8'h09, 8'h05, 1'b0, n);
      push_all(32'h006F3F6D, n);
      goto(n + 2 + 65 * 3 + 3);
      start_frame(8'h1A, 8'hFF, 1'b0, n);
      push_all(32'h06404040, n);
      goto(n + 2 + 65 * 3 + 3);

      // Starts during a frame are ignored; input changes after capture are too.
      start_frame(8'h23, 8'h59, 1'b1, n);
      push_all(model_word(8'h23, 8'h59, 1'b1), n);
      goto(n + 5);
      hours   = 8'h07;
      minutes = 8'h48;
      colon   = 1'b0;
      goto(n + 10);
      start = 1'b1;
      goto(n + 11);
      start = 1'b0;
      goto(n + 50);
      start = 1'b1;
      goto(n + 51);
      start = 1'b0;
      goto(n + 2 + 65 * 3 + 3);

      // Start held high: each instance restarts on its first IDLE cycle.
      hours   = 8'h10;
      minutes = 8'h07;
      colon   = 1'b1;
      start   = 1'b1;
      n       = cyc;
      for (int i = 0; i < 3; i++) begin
         s = n;
         while (s <= n + 200) begin
            push_one(i, model_word(8'h10, 8'h07, 1'b1), s);
            s = s + 3 + 65 * div_of(i);
         end
      end
      goto(n + 201);
      start = 1'b0;
      goto(n + 420);

      // Enable dropped mid-frame: abort, no latch, no done; then a clean frame.
      start_frame(8'h11, 8'h22, 1'b1, n);
      goto(n + 40);
      en = 1'b0;
      goto(n + 41);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_all_zero("abort_outputs_zero");
         @(posedge clk);
         #1;
      end
      en = 1'b1;
      start_frame(8'h05, 8'h30, 1'b0, n);
      push_all(model_word(8'h05, 8'h30, 1'b0), n);
      goto(n + 2 + 65 * 3 + 3);

      // Asynchronous reset while the shift clock is high.
      start_frame(8'h22, 8'h22, 1'b1, n);
      goto(n + 20);
      found = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (sclk[0]) begin
            found = 1;
            break;
         end
      end
      check("reset_wait_sclk_high", 0, found, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset_outputs");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      start_frame(8'h21, 8'h09, 1'b1, n);
      push_all(model_word(8'h21, 8'h09, 1'b1), n);
      goto(n + 2 + 65 * 3 + 3);

      // Random frames, including non-decimal digit codes.
      for (int k = 0; k < 6; k++) begin
         h = 8'($urandom);
         m = 8'($urandom);
         c = 1'($urandom);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         start_frame(h, m, c, n);
         push_all(model_word(h, m, c), n);
         goto(n + 2 + 65 * 3 + 3);
      end

      goto(cyc + 10);
      check("pending_frames", 0, q0.size(), 32'd0);
      check("pending_frames", 1, q1.size(), 32'd0);
      check("pending_frames", 2, q2.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_display_sequencer.md
SERIAL_DISPLAY_SEQUENCER -- requirements
Module: serial_display_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 2, meaning i_clk cycles per half-period of the serial shift clock; SHALL be >= 1.
REQ-002 i_clk  input  1  system clock; all state SHALL be updated on its rising edge only.
REQ-003 i_reset_n  input  1  reset, asynchronous and active-low.
REQ-004 i_en  input  1  block enable; low SHALL force IDLE.
REQ-005 i_start  input  1  frame request, sampled in IDLE only.
REQ-006 i_hours_bcd  input  8  hours, {tens[7:4], ones[3:0]} BCD.
REQ-007 i_minutes_bcd  input  8  minutes, {tens[7:4], ones[3:0]} BCD.
REQ-008 i_colon  input  1  colon indicator, shown on the decimal point of the hours-ones digit.
REQ-009 o_busy  output  1  frame in progress.
REQ-010 o_done  output  1  one-cycle pulse at frame completion.
REQ-011 o_serial_data  output  1  shift register data line.
REQ-012 o_serial_clk  output  1  shift clock; external register samples on its rising edge.
REQ-013 o_serial_latch  output  1  storage latch strobe, active high.

Function
REQ-014 Segment byte SHALL be {dp,g,f,e,d,c,b,a}, active high; 0..9 SHALL map to 3F,06,5B,4F,66,6D,7D,07,7F,6F hex; codes 10..15 SHALL map to 40 hex (dash).
REQ-015 Hours-tens digit equal to 0 SHALL encode as 00 hex (leading-zero blank); other digits are never blanked.
REQ-016 The dp bit SHALL be i_colon for the hours-ones digit and 0 for all other digits.
REQ-017 Frame SHALL be 32 bits: hours-tens byte, hours-ones byte, minutes-tens byte, minutes-ones byte, each byte MSB first.
REQ-018 States SHALL be IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, DONE.
REQ-019 IDLE -> LOAD when i_en=1 and i_start=1 at a clock edge (cycle N); all inputs SHALL be captured into the 32-bit frame register at that edge; later input changes SHALL not affect the frame.
REQ-020 LOAD lasts 1 cycle (N+1) and presents frame bit 31 on o_serial_data with o_serial_clk=0.
REQ-021 SHIFT_LO lasts CLK_DIV cycles with o_serial_clk=0 and the current bit stable; SHIFT_HI lasts CLK_DIV cycles with o_serial_clk=1 and the same bit stable.
REQ-022 After SHIFT_HI of bits 31..1 the next bit SHALL be presented on entry to SHIFT_LO; after SHIFT_HI of bit 0 the FSM SHALL enter LATCH.
REQ-023 LATCH lasts CLK_DIV cycles with o_serial_latch=1, o_serial_clk=0, o_serial_data=0.
REQ-024 DONE lasts 1 cycle: o_done=1, o_busy=0, then IDLE; o_done SHALL be high in cycle N+2+65*CLK_DIV exactly.
REQ-025 o_busy SHALL be 1 in LOAD, SHIFT_LO, SHIFT_HI, LATCH and 0 in IDLE and DONE.
REQ-026 i_start while not in IDLE SHALL be ignored (no queuing); i_start in DONE SHALL be ignored; i_start held high SHALL start a new frame from the first IDLE cycle.
REQ-027 i_en=0 in any state SHALL move to IDLE at the next edge with o_serial_clk, o_serial_data, o_serial_latch, o_busy=0; no latch pulse and no o_done SHALL be issued for an aborted frame.
REQ-028 Bit and divider counters SHALL be sized for 32 bits and CLK_DIV without wrap; the divider SHALL reload on every state change.
REQ-029 All outputs SHALL be registered (glitch-free).

Reset
REQ-030 i_reset_n=0 SHALL immediately force IDLE and all outputs to 0, clearing frame, bit and divider counters, regardless of i_clk.
REQ-031 Reset deassertion mid-frame SHALL resume from IDLE; the interrupted frame is discarded.

Verification
REQ-032 CLK_DIV=2, hours=12, minutes=34, colon=1, start pulse at N -> shifted word 06DB4F66 hex MSB first, latch high cycles N+130..N+131, o_done at N+132 only.
REQ-033 hours=09, minutes=05, colon=0 -> word 006F3F6D hex (hours tens blanked).
REQ-034 hours=1A, minutes=FF -> word 06404040 hex.
REQ-035 i_start pulsed at N+10 and N+50 during a frame -> exactly one frame, single o_done; inputs changed at N+5 -> no effect on shifted word.
REQ-036 i_en dropped at N+40 -> all outputs 0 from N+41, no latch, no o_done; next start produces a full correct frame.
REQ-037 i_reset_n asserted mid-SHIFT_HI between clock edges -> outputs 0 before next edge; o_serial_clk period = 2*CLK_DIV cycles checked for CLK_DIV=1 and 3.
